// File: rtl/usb_host_pkg.sv
// Shared constants and types for the USB full-speed host token transmitter.
package usb_host_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  localparam logic [4:0] CRC5_POLY = 5'b00101;
  localparam logic [4:0] CRC5_INIT = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOKEN,
    ST_CRC,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  // Bus line state packed as {d_plus, d_minus}
  typedef logic [1:0] line_t;
  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  function automatic logic pid_is_token(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SOF) || (p == PID_SETUP);
  endfunction

endpackage

// File: rtl/usb_crc5.sv
// Serial USB CRC5 (x^5+x^2+1); remainder register updated one bit per shift_en.
module usb_crc5
  import usb_host_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_shift_en,
  input  logic       i_bit_in,
  output logic [4:0] o_rem
);

  logic [4:0] r_rem;
  logic       w_fb;

  assign w_fb  = i_bit_in ^ r_rem[4];
  assign o_rem = r_rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem <= CRC5_INIT;
    end else if (i_clear) begin
      r_rem <= CRC5_INIT;
    end else if (i_shift_en) begin
      r_rem <= {r_rem[3:0], 1'b0} ^ (w_fb ? CRC5_POLY : 5'b00000);
    end
  end

endmodule

// File: rtl/usb_host_token_tx.sv
// USB full-speed token transmitter: SYNC/PID/ADDR/ENDP/CRC5/EOP with bit stuffing and NRZI.
// Optional build macro TOKEN_PID_CHECK_EN refuses non-token PIDs and pulses err.
module usb_host_token_tx
  import usb_host_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
)
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic [6:0] addr,
  input  logic [3:0] endp,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  tx_state_t        r_state, w_nxt_state;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit_cnt, w_nxt_bit;
  logic [3:0]       r_fld_cnt, w_nxt_fld;
  logic [2:0]       r_ones;
  line_t            r_line, w_line_tgl;
  logic             r_busy, r_done;
  logic [3:0]       r_pid, r_endp;
  logic [6:0]       r_addr;

  logic             w_pid_ok, w_accept, w_bit_end, w_data_st, w_stuff;
  logic             w_nxt_data, w_crc_shift;
  logic [7:0]       w_pid_byte;
  logic [10:0]      w_tok;
  logic [4:0]       w_crc_rem;
  logic [2:0]       w_crc_idx;

`ifdef TOKEN_PID_CHECK_EN
  logic r_err;
  assign w_pid_ok = pid_is_token(pid);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_err <= 1'b0;
    else        r_err <= (r_state == ST_IDLE) && start && !w_pid_ok;
  end
  assign err = r_err;
`else
  assign w_pid_ok = 1'b1;
  assign err      = 1'b0;
`endif

  assign w_accept   = (r_state == ST_IDLE) && start && w_pid_ok;
  assign w_bit_end  = (r_state != ST_IDLE) && (r_div == DIV_LAST);
  assign w_data_st  = (r_state == ST_SYNC) || (r_state == ST_PID) ||
                      (r_state == ST_TOKEN) || (r_state == ST_CRC);
  assign w_stuff    = w_data_st && (r_ones == 3'd6);
  assign w_line_tgl = (r_line == LINE_J) ? LINE_K : LINE_J;
  assign w_pid_byte = {~r_pid, r_pid};
  assign w_tok      = {r_endp, r_addr};
  assign w_crc_idx  = 3'd4 - w_nxt_fld[2:0];

  // Position of the next data bit once the current bit time ends
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_bit   = r_bit_cnt;
    w_nxt_fld   = r_fld_cnt;
    case (r_state)
      ST_SYNC: begin
        w_nxt_bit = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          w_nxt_state = ST_PID;
          w_nxt_bit   = 3'd0;
        end
      end
      ST_PID: begin
        w_nxt_bit = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          w_nxt_state = ST_TOKEN;
          w_nxt_bit   = 3'd0;
          w_nxt_fld   = 4'd0;
        end
      end
      ST_TOKEN: begin
        w_nxt_fld = r_fld_cnt + 4'd1;
        if (r_fld_cnt == 4'd10) begin
          w_nxt_state = ST_CRC;
          w_nxt_fld   = 4'd0;
        end
      end
      ST_CRC: begin
        w_nxt_fld = r_fld_cnt + 4'd1;
        if (r_fld_cnt == 4'd4) begin
          w_nxt_state = ST_EOP_SE0;
          w_nxt_fld   = 4'd0;
          w_nxt_bit   = 3'd0;
        end
      end
      ST_EOP_SE0: begin
        w_nxt_bit = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd1) w_nxt_state = ST_EOP_J;
      end
      ST_EOP_J: w_nxt_state = ST_IDLE;
      default:  w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_nxt_data = 1'b1;
    case (w_nxt_state)
      ST_SYNC:  w_nxt_data = (w_nxt_bit == 3'd7);
      ST_PID:   w_nxt_data = w_pid_byte[w_nxt_bit];
      ST_TOKEN: w_nxt_data = w_tok[w_nxt_fld];
      ST_CRC:   w_nxt_data = ~w_crc_rem[w_crc_idx];
      default:  w_nxt_data = 1'b1;
    endcase
  end

  assign w_crc_shift = w_bit_end && !w_stuff && (w_nxt_state == ST_TOKEN);

  usb_crc5 u_crc5 (
    .i_clk      (clk),
    .i_rst_n    (n_rst),
    .i_clear    (w_accept),
    .i_shift_en (w_crc_shift),
    .i_bit_in   (w_nxt_data),
    .o_rem      (w_crc_rem)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pid  <= pid;
      r_addr <= addr;
      r_endp <= endp;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_div     <= '0;
      r_bit_cnt <= 3'd0;
      r_fld_cnt <= 4'd0;
      r_ones    <= 3'd0;
      r_line    <= LINE_J;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // First SYNC bit is a 0, so the line leaves J immediately
        r_state   <= ST_SYNC;
        r_div     <= '0;
        r_bit_cnt <= 3'd0;
        r_fld_cnt <= 4'd0;
        r_ones    <= 3'd0;
        r_line    <= LINE_K;
        r_busy    <= 1'b1;
      end else if (w_bit_end) begin
        r_div <= '0;
        if (w_stuff) begin
          r_line <= w_line_tgl;
          r_ones <= 3'd0;
        end else begin
          r_state   <= w_nxt_state;
          r_bit_cnt <= w_nxt_bit;
          r_fld_cnt <= w_nxt_fld;
          case (w_nxt_state)
            ST_EOP_SE0: begin
              r_line <= LINE_SE0;
              r_ones <= 3'd0;
            end
            ST_EOP_J: r_line <= LINE_J;
            ST_IDLE: begin
              r_line    <= LINE_J;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_bit_cnt <= 3'd0;
              r_fld_cnt <= 4'd0;
              r_ones    <= 3'd0;
            end
            default: begin
              r_line <= w_nxt_data ? r_line : w_line_tgl;
              r_ones <= w_nxt_data ? (r_ones + 3'd1) : 3'd0;
            end
          endcase
        end
      end else if (r_state != ST_IDLE) begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign d_plus  = r_line[1];
  assign d_minus = r_line[0];

endmodule
